// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 set-2 scancode decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_PAUSE
  } ps2_state_e;

  typedef struct packed {
    logic       released;
    logic       extended;
    logic [7:0] code;
  } ps2_event_t;

  localparam logic [7:0] PS2_PFX_EXT     = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK     = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE   = 8'hE1;

  localparam logic [7:0] PS2_RPY_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RPY_BAT     = 8'hAA;
  localparam logic [7:0] PS2_RPY_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_RPY_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_RPY_ERR0    = 8'h00;
  localparam logic [7:0] PS2_RPY_ERR1    = 8'hFF;

  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_PAUSE_CODE  = 8'h77;
  localparam logic [2:0] PS2_PAUSE_LAST  = 3'd6;

  function automatic logic ps2_is_reply(input logic [7:0] b);
    return b inside {PS2_RPY_ACK, PS2_RPY_BAT, PS2_RPY_ECHO,
                     PS2_RPY_RESEND, PS2_RPY_ERR0, PS2_RPY_ERR1};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Power-of-two event FIFO; a push on full is accepted only if a pop frees a slot that cycle.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 set-2 prefix sequences into key events and buffers them for the slowIO side.
// Optional typematic-repeat suppression is built when PS2_REPEAT_FILTER_EN is defined.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       in_error,
  output logic       event_valid,
  output logic [9:0] event_data,
  input  logic       event_ready,
  output logic [7:0] status_byte,
  output logic       status_strobe,
  output logic       overflow,
  input  logic       clear_overflow
);

  ps2_state_e state, next_state;
  logic [2:0] pause_cnt, next_cnt;
  ps2_event_t cand;
  logic       cand_valid;
  logic       cand_pause;
  logic       status_upd;
  logic       is_fake;
  logic       push;
  logic [$bits(ps2_event_t)-1:0] fifo_head;
  logic       fifo_empty;
  logic       fifo_full_unused;
  logic       fifo_dropped;

  assign is_fake = (in_byte == PS2_FAKE_LSHIFT) || (in_byte == PS2_FAKE_RSHIFT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      pause_cnt <= '0;
    end else begin
      state     <= next_state;
      pause_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = pause_cnt;
    cand       = '0;
    cand_valid = 1'b0;
    cand_pause = 1'b0;
    status_upd = 1'b0;
    if (in_valid) begin
      if (in_error) begin
        next_state = ST_IDLE;
        next_cnt   = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_byte == PS2_PFX_EXT) next_state = ST_E0;
            else if (in_byte == PS2_PFX_BRK) next_state = ST_F0;
            else if (in_byte == PS2_PFX_PAUSE) begin
              next_state = ST_PAUSE;
              next_cnt   = '0;
            end else if (ps2_is_reply(in_byte)) status_upd = 1'b1;
            else begin
              cand       = '{released: 1'b0, extended: 1'b0, code: in_byte};
              cand_valid = 1'b1;
            end
          end
          ST_E0: begin
            if (in_byte == PS2_PFX_BRK) next_state = ST_E0F0;
            else begin
              next_state = ST_IDLE;
              cand       = '{released: 1'b0, extended: 1'b1, code: in_byte};
              cand_valid = !is_fake;
            end
          end
          ST_F0: begin
            next_state = ST_IDLE;
            cand       = '{released: 1'b1, extended: 1'b0, code: in_byte};
            cand_valid = 1'b1;
          end
          ST_E0F0: begin
            next_state = ST_IDLE;
            cand       = '{released: 1'b1, extended: 1'b1, code: in_byte};
            cand_valid = !is_fake;
          end
          ST_PAUSE: begin
            if (pause_cnt == PS2_PAUSE_LAST) begin
              next_state = ST_IDLE;
              next_cnt   = '0;
              cand       = '{released: 1'b0, extended: 1'b1, code: PS2_PAUSE_CODE};
              cand_valid = 1'b1;
              cand_pause = 1'b1;
            end else begin
              next_cnt = pause_cnt + 3'd1;
            end
          end
          default: next_state = ST_IDLE;
        endcase
      end
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  // Held map tracks keys by {extended, code}; it is updated even when the FIFO drops the event.
  logic [511:0] held;
  logic [8:0]   held_idx;

  assign held_idx = {cand.extended, cand.code};
  assign push     = cand_valid && (cand_pause || cand.released || !held[held_idx]);

  always_ff @(posedge clock) begin
    if (reset) held <= '0;
    else if (status_upd && (in_byte == PS2_RPY_BAT)) held <= '0;
    else if (cand_valid && !cand_pause) held[held_idx] <= !cand.released;
  end
`else
  logic unused_pause;
  assign unused_pause = cand_pause;
  assign push         = cand_valid;
`endif

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(ps2_event_t))
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(cand),
    .pop      (event_ready),
    .head     (fifo_head),
    .full     (fifo_full_unused),
    .empty    (fifo_empty),
    .dropped  (fifo_dropped)
  );

  assign event_valid = !fifo_empty;
  assign event_data  = event_valid ? fifo_head : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      status_byte   <= '0;
      status_strobe <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      status_strobe <= status_upd;
      if (status_upd) status_byte <= in_byte;
      if (fifo_dropped) overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: sequence-level reference model feeds expected
// events/status bytes into queues; a negedge monitor compares whatever the DUT presents.
module tb_ps2_scancode_decoder;

  localparam int unsigned DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_error;
  logic       event_valid;
  logic [9:0] event_data;
  logic       event_ready;
  logic [7:0] status_byte;
  logic       status_strobe;
  logic       overflow;
  logic       clear_overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [9:0] sb[$];
  logic [7:0] exp_status[$];
  logic [7:0] pend[$];
  bit         held[512];
  bit         exp_overflow = 1'b0;
  logic [7:0] last_status  = 8'h00;

  always #5 clock = ~clock;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .in_error      (in_error),
    .event_valid   (event_valid),
    .event_data    (event_data),
    .event_ready   (event_ready),
    .status_byte   (status_byte),
    .status_strobe (status_strobe),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (event_valid && event_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL event_unexpected: got %03h, required no event", event_data);
      end else check("event", event_data, sb.pop_front());
    end
    if (status_strobe) begin
      if (exp_status.size() == 0) begin
        n_checks++;
        $display("FAIL status_unexpected: got strobe with %02h, required no strobe", status_byte);
      end else check("status", status_byte, exp_status.pop_front());
    end
  end

  function automatic bit is_reply(input logic [7:0] b);
    return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic emit(input bit rel, input bit ext, input logic [7:0] code, input bit pause);
`ifdef PS2_REPEAT_FILTER_EN
    int unsigned idx;
    idx = {23'd0, ext, code};
    if (!pause) begin
      if (!rel) begin
        if (held[idx]) return;
        held[idx] = 1'b1;
      end else held[idx] = 1'b0;
    end
`endif
    if (sb.size() >= DEPTH && !event_ready) begin
      exp_overflow = 1'b1;
      return;
    end
    sb.push_back({rel, ext, code});
  endtask

  // Reference: accumulate prefix bytes, resolve the event once a non-prefix byte completes it.
  task automatic model_byte(input logic [7:0] b, input bit err);
    bit ext, rel;
    if (err) begin
      pend.delete();
      return;
    end
    if (pend.size() != 0 && pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == 8) begin
        pend.delete();
        emit(1'b0, 1'b1, 8'h77, 1'b1);
      end
      return;
    end
    if (pend.size() == 0 && is_reply(b)) begin
      exp_status.push_back(b);
      last_status = b;
      if (b == 8'hAA) held = '{default: 1'b0};
      return;
    end
    if ((pend.size() == 0 && (b == 8'hE0 || b == 8'hF0 || b == 8'hE1)) ||
        (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0)) begin
      pend.push_back(b);
      return;
    end
    ext = (pend.size() != 0 && pend[0] == 8'hE0);
    rel = (pend.size() != 0 && pend[pend.size()-1] == 8'hF0);
    pend.delete();
    if (ext && (b == 8'h12 || b == 8'h59)) return;
    emit(rel, ext, b, 1'b0);
  endtask

  task automatic send(input logic [7:0] b, input bit err = 1'b0);
    in_byte  = b;
    in_error = err;
    in_valid = 1'b1;
    model_byte(b, err);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_error = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    event_ready = 1'b1;
    while ((sb.size() != 0 || event_valid) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] codes [8] = '{8'h1C, 8'h12, 8'h59, 8'h75, 8'h23, 8'h2B, 8'h7C, 8'h14};
    logic [7:0] makes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    logic [7:0] b;
    int unsigned sel, n;

    reset = 1'b1; in_valid = 1'b0; in_byte = '0; in_error = 1'b0;
    event_ready = 1'b0; clear_overflow = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_event_valid", event_valid, 0);
    check("rst_event_data", event_data, 0);
    check("rst_status_byte", status_byte, 0);
    check("rst_status_strobe", status_strobe, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    event_ready = 1'b1;
    @(posedge clock); #1;

    // make / break of 'A', including one-cycle latency
    send(8'h1C);
    check("latency_valid", event_valid, 1);
    check("latency_data", event_data, 10'h01C);
    send(8'hF0); send(8'h1C);
    // extended make/break, fake shift swallowed
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
    // pause sequence then back in IDLE
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();

    // framing error aborts prefix; status reply
    send(8'hE0); send(8'h55, 1'b1); send(8'h1C);
    send(8'hFA);
    check("status_strobe_on", status_strobe, 1);
    check("status_byte_fa", status_byte, 8'hFA);
    @(posedge clock); #1;
    check("status_strobe_off", status_strobe, 0);
    send(8'hF0); send(8'h1C);

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    drain();

    // overflow: nine makes into an eight-deep FIFO with no pops
    event_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(makes[i]);
    check("overflow_set", overflow, exp_overflow);
    clear_overflow = 1'b1;
    send(8'h4B);
    clear_overflow = 1'b0;
    check("overflow_clear_vs_drop", overflow, 1);
    event_ready = 1'b1;
    send(8'h4C);
    check("full_push_pop_kept", overflow, 1);
    clear_overflow = 1'b1;
    @(posedge clock); #1;
    clear_overflow = 1'b0;
    exp_overflow = 1'b0;
    check("overflow_cleared", overflow, 0);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      n = 0;
      while (sb.size() >= 6 && n < 200) begin
        event_ready = 1'b1;
        @(posedge clock); #1;
        n++;
      end
      if (n >= 200) check("rand_wait_bound", n, 0);
      event_ready = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 99);
      if (sel < 10)      b = 8'hE0;
      else if (sel < 20) b = 8'hF0;
      else if (sel < 23) b = 8'hE1;
      else if (sel < 31) begin
        sel = $urandom_range(0, 5);
        b = (sel == 0) ? 8'hFA : (sel == 1) ? 8'hAA : (sel == 2) ? 8'hEE :
            (sel == 3) ? 8'hFE : (sel == 4) ? 8'h00 : 8'hFF;
      end
      else if (sel < 88) b = codes[$urandom_range(0, 7)];
      else               b = 8'($urandom_range(0, 255));
      send(b, ($urandom_range(0, 24) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end
    drain();
    check("final_overflow", overflow, exp_overflow);
    check("final_status_hold", status_byte, last_status);
    check("final_status_left", exp_status.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
